data_cache: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate data cache between the CPU data port and the

---
 rtl/data_cache_if.sv | 16 +
 rtl/data_cache.sv | 163 ++++++++++++++++
 tb/tb_data_cache.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_if.sv
// CPU-side request/response bundle for data_cache.
// Handshake: the master raises cpu_read or cpu_write and holds cpu_addr and cpu_wdata stable; the
// slave completes the request with a one-cycle cpu_ready pulse (cpu_rdata is valid in that cycle for reads).
interface data_cache_if;
   logic        cpu_read;
   logic        cpu_write;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_ready;

   modport master (output cpu_read, cpu_write, cpu_addr, cpu_wdata,
                   input  cpu_rdata, cpu_ready);
   modport slave  (input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
                   output cpu_rdata, cpu_ready);
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with line fill over a fixed-latency port.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module data_cache #(
   parameter int INDEX_BITS  = 2,
   parameter int OFFSET_BITS = 2,
   parameter int MEM_LATENCY = 5
) (
   input  logic        clk,
   input  logic        reset_n,
   data_cache_if.slave cpu,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic [15:0] mem_addr_o,
   inout  wire  [15:0] mem_data_io,
   output logic [1:0]  dbg_state_o
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0] hit_count_o,
   output logic [15:0] miss_count_o
`endif
);
   localparam int LINES      = 1 << INDEX_BITS;
   localparam int LINE_WORDS = 1 << OFFSET_BITS;
   localparam int TAG_W      = 16 - OFFSET_BITS - INDEX_BITS;
   localparam int LAT_W      = $clog2(MEM_LATENCY + 1);
   localparam logic [LAT_W-1:0]       LAT_LAST  = LAT_W'(MEM_LATENCY - 1);
   localparam logic [OFFSET_BITS-1:0] WORD_LAST = OFFSET_BITS'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

   state_t state_q, state_d;

   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [15:0]       data_q [LINES*LINE_WORDS];

   logic [15:0]            req_addr_q;
   logic [15:0]            wdata_q;
   logic                   wr_hit_q;
   logic [OFFSET_BITS-1:0] word_q;
   logic [LAT_W-1:0]       lat_q;
   logic [15:0]            rdata_q;

   logic [TAG_W-1:0]       in_tag, req_tag;
   logic [INDEX_BITS-1:0]  in_idx, req_idx;
   logic [OFFSET_BITS-1:0] in_off, req_off;
   logic                   in_hit;
   logic                   word_done;
   logic                   fill_last;

   assign in_tag  = cpu.cpu_addr[15:OFFSET_BITS+INDEX_BITS];
   assign in_idx  = cpu.cpu_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
   assign in_off  = cpu.cpu_addr[OFFSET_BITS-1:0];
   assign req_tag = req_addr_q[15:OFFSET_BITS+INDEX_BITS];
   assign req_idx = req_addr_q[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
   assign req_off = req_addr_q[OFFSET_BITS-1:0];

   assign in_hit    = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
   assign word_done = (lat_q == LAT_LAST);
   assign fill_last = word_done && (word_q == WORD_LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cpu.cpu_write)     state_d = WRITE;
            else if (cpu.cpu_read) state_d = in_hit ? DONE : FILL;
         end
         FILL:    if (fill_last) state_d = DONE;
         WRITE:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_read_o    = (state_q == FILL);
      mem_write_o   = (state_q == WRITE);
      mem_addr_o    = '0;
      cpu.cpu_ready = (state_q == DONE);
      cpu.cpu_rdata = rdata_q;
      dbg_state_o   = state_q;
      if (state_q == FILL)       mem_addr_o = {req_tag, req_idx, word_q};
      else if (state_q == WRITE) mem_addr_o = req_addr_q;
   end

   assign mem_data_io = mem_write_o ? wdata_q : 16'hzzzz;

   // Control and status registers; everything here returns to its reset value, aborting any fill.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q    <= '0;
         req_addr_q <= '0;
         wdata_q    <= '0;
         wr_hit_q   <= 1'b0;
         word_q     <= '0;
         lat_q      <= '0;
         rdata_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cpu.cpu_write) begin
                  req_addr_q <= cpu.cpu_addr;
                  wdata_q    <= cpu.cpu_wdata;
                  wr_hit_q   <= in_hit;
               end else if (cpu.cpu_read) begin
                  req_addr_q <= cpu.cpu_addr;
                  word_q     <= '0;
                  lat_q      <= '0;
                  if (in_hit) rdata_q <= data_q[{in_idx, in_off}];
               end
            end
            FILL: begin
               if (word_done) begin
                  lat_q  <= '0;
                  word_q <= word_q + 1'b1;
                  if (word_q == WORD_LAST) begin
                     valid_q[req_idx] <= 1'b1;
                     // The requested word may be the one arriving at this very edge.
                     rdata_q <= (word_q == req_off) ? mem_data_io : data_q[{req_idx, req_off}];
                  end
               end else begin
                  lat_q <= lat_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         if (state_q == FILL && word_done) begin
            data_q[{req_idx, word_q}] <= mem_data_io;
            if (word_q == WORD_LAST) tag_q[req_idx] <= req_tag;
         end else if (state_q == WRITE && wr_hit_q) begin
            data_q[{req_idx, req_off}] <= wdata_q;
         end
      end
   end

`ifdef DCACHE_STATS_EN
   logic [15:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (state_q == IDLE && (cpu.cpu_write || cpu.cpu_read)) begin
         if (in_hit) hit_cnt_q  <= hit_cnt_q + 16'd1;
         else        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
   end

   assign hit_count_o  = hit_cnt_q;
   assign miss_count_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: drivers push expectations, negedge monitors pop and compare.
// Memory model returns 16'hDEAD until an address has been held for MEM_LATENCY cycles.
module tb_data_cache;
   localparam int MEM_LATENCY = 5;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        mem_read, mem_write;
   logic [15:0] mem_addr;
   wire  [15:0] mem_data;
   logic [1:0]  dbg_state;
`ifdef DCACHE_STATS_EN
   logic [15:0] hit_count, miss_count;
`endif

   data_cache_if cif ();

   data_cache #(.INDEX_BITS(2), .OFFSET_BITS(2), .MEM_LATENCY(MEM_LATENCY)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cpu         (cif),
      .mem_read_o  (mem_read),
      .mem_write_o (mem_write),
      .mem_addr_o  (mem_addr),
      .mem_data_io (mem_data),
      .dbg_state_o (dbg_state)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count_o  (hit_count),
      .miss_count_o (miss_count)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- memory model ----------------
   logic [15:0] mem [256];
   logic [15:0] run_addr = '0;
   logic        run_valid = 1'b0;
   int          run_cnt = 0;
   logic        mem_ok;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {8'hC0, 8'(i)};
      mem[0] = 16'h9023;
      mem[1] = 16'h0001;
      mem[2] = 16'hFFFF;
   end

   assign mem_ok   = mem_read && run_valid && (mem_addr == run_addr) && (run_cnt >= MEM_LATENCY - 1);
   assign mem_data = mem_read ? (mem_ok ? mem[mem_addr[7:0]] : 16'hDEAD) : 16'hzzzz;

   always @(posedge clk) begin
      run_cnt   <= (mem_read && run_valid && mem_addr == run_addr) ? run_cnt + 1 : 1;
      run_addr  <= mem_addr;
      run_valid <= mem_read;
      if (mem_write) mem[mem_addr[7:0]] <= mem_data;
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;

   logic [15:0] exp_q[$];
   logic [31:0] mem_exp_q[$];
   int          exp_lat_q[$];
   int          exp_rd_q[$];
   int          iss_q[$];
   bit          exp_wr_q[$];
   int          rd_cnt = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         rd_cnt = 0;
      end else begin
         if (cif.cpu_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_ready", 16'd1, 16'd0);
            end else begin
               logic [15:0] e;
               int lat, rdc, iss;
               bit wr;
               e = exp_q.pop_front();   lat = exp_lat_q.pop_front();
               rdc = exp_rd_q.pop_front(); iss = iss_q.pop_front();
               wr = exp_wr_q.pop_front();
               if (!wr) chk("rdata", cif.cpu_rdata, e);
               chk("latency", 16'(cyc - iss + 1), 16'(lat));
               chk("mem_read_cycles", 16'(rd_cnt), 16'(rdc));
            end
            rd_cnt = 0;
         end
         if (mem_read) rd_cnt++;
      end
   end

   always @(negedge clk) begin
      if (reset_n && (mem_read || mem_write)) begin
         chk("rd_wr_exclusive", {15'd0, mem_read && mem_write}, 16'd0);
         if (mem_write) begin
            if (mem_exp_q.size() == 0) begin
               chk("unexpected_mem_write", 16'd1, 16'd0);
            end else begin
               logic [31:0] m;
               m = mem_exp_q.pop_front();
               chk("mem_write_addr", mem_addr, m[31:16]);
               chk("mem_write_data", mem_data, m[15:0]);
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic do_req(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_data, input int exp_lat, input int exp_rd);
      int n;
      @(negedge clk);
      cif.cpu_read  = !wr;
      cif.cpu_write = wr;
      cif.cpu_addr  = addr;
      cif.cpu_wdata = wdata;
      exp_q.push_back(exp_data);
      exp_lat_q.push_back(exp_lat);
      exp_rd_q.push_back(exp_rd);
      exp_wr_q.push_back(wr);
      iss_q.push_back(cyc + 1);
      if (wr) mem_exp_q.push_back({addr, wdata});
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cif.cpu_ready && n < 100);
      if (!cif.cpu_ready) chk("ready_timeout", 16'd0, 16'd1);
      cif.cpu_read  = 1'b0;
      cif.cpu_write = 1'b0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_cpu_ready", {15'd0, cif.cpu_ready}, 16'd0);
      chk("rst_cpu_rdata", cif.cpu_rdata, 16'd0);
      chk("rst_mem_read",  {15'd0, mem_read}, 16'd0);
      chk("rst_mem_write", {15'd0, mem_write}, 16'd0);
      chk("rst_mem_addr",  mem_addr, 16'd0);
      chk("rst_state",     {14'd0, dbg_state}, 16'd0);
   endtask

   initial begin
      cif.cpu_read  = 1'b0;
      cif.cpu_write = 1'b0;
      cif.cpu_addr  = '0;
      cif.cpu_wdata = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs();
      reset_n = 1'b1;

      // cold miss, then hits in the filled line
      do_req(1'b0, 16'h0001, 16'h0, 16'h0001, 21, 20);
      do_req(1'b0, 16'h0002, 16'h0, 16'hFFFF, 1, 0);
      do_req(1'b0, 16'h0000, 16'h0, 16'h9023, 1, 0);
`ifdef DCACHE_STATS_EN
      @(negedge clk);
      chk("hit_count",  hit_count,  16'd2);
      chk("miss_count", miss_count, 16'd1);
`endif
      // write hit updates cache and memory
      do_req(1'b1, 16'h0002, 16'h1234, 16'h0, 2, 0);
      do_req(1'b0, 16'h0002, 16'h0, 16'h1234, 1, 0);
      // write miss leaves line 0 untouched, later read fills from memory
      do_req(1'b1, 16'h0041, 16'hBEEF, 16'h0, 2, 0);
      do_req(1'b0, 16'h0002, 16'h0, 16'h1234, 1, 0);
      do_req(1'b0, 16'h0041, 16'h0, 16'hBEEF, 21, 20);
      // conflict misses on index 0
      do_req(1'b0, 16'h0001, 16'h0, 16'h0001, 21, 20);
      do_req(1'b0, 16'h0011, 16'h0, 16'hC011, 21, 20);
      do_req(1'b0, 16'h0001, 16'h0, 16'h0001, 21, 20);
      do_req(1'b0, 16'h0012, 16'h0, 16'hC012, 21, 20);
      do_req(1'b0, 16'h0002, 16'h0, 16'h1234, 21, 20);
      // top of address space, requested word is the last of the line
      do_req(1'b0, 16'hFFFF, 16'h0, 16'hC0FF, 21, 20);
      do_req(1'b0, 16'hFFFC, 16'h0, 16'hC0FC, 1, 0);
      do_req(1'b1, 16'hFFFE, 16'h7777, 16'h0, 2, 0);
      do_req(1'b0, 16'hFFFE, 16'h0, 16'h7777, 1, 0);

      // reset during the third FILL cycle aborts the fill
      @(negedge clk);
      cif.cpu_read = 1'b1;
      cif.cpu_addr = 16'h0021;
      repeat (2) @(negedge clk);
      chk("abort_fill_active", {15'd0, mem_read}, 16'd1);
      @(negedge clk);
      reset_n      = 1'b0;
      cif.cpu_read = 1'b0;
      @(negedge clk);
      chk_reset_outputs();
      @(negedge clk);
      reset_n = 1'b1;
      do_req(1'b0, 16'h0021, 16'h0, 16'hC021, 21, 20);
      do_req(1'b0, 16'h0001, 16'h0, 16'h0001, 21, 20);

      repeat (5) @(negedge clk);
      chk("pending_expectations", 16'(exp_q.size() + mem_exp_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
